// File: rtl/config_pkg.sv
// Build-time configuration shared by the fetch front end.
package config_pkg;
  localparam logic [31:0] CFG_BOOT_ADDR = 32'h0000_0100;
endpackage

// File: rtl/data_bus_pkg.sv
// Types carried between the instruction bus, the fetch buffer and decode.
package data_bus_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries; head is zero while empty so decode sees clean idle outputs.
module ifetch_fifo
  import data_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok && !clear) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher: issues word fetches against a credit of DEPTH,
// buffers responses and discards responses that belong to a flushed stream.
module ifetch_prefetch
  import config_pkg::*;
  import data_bus_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = CFG_BOOT_ADDR,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_err
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   BOOT_PC = BOOT_ADDR & 32'hFFFF_FFFC;

  logic          req_q, req_d, halted_q, halted_d, stale_q, stale_d;
  logic [31:0]   addr_q, addr_d, fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count_d;
  logic [CW:0]   occ;
  logic          grant, hold, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;

  assign grant = req_q & ibus_gnt;
  assign hold  = req_q & ~ibus_gnt;
  assign push  = ibus_rvalid & ~flush & (discard_q == '0);
  assign pop   = ~fifo_empty & instr_ready & ~flush;

  always_comb begin
    halted_d   = halted_q;
    stale_d    = stale_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(grant) - CW'(ibus_rvalid);
    count_d    = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
    if (flush) begin
      // Everything granted so far belongs to the old stream, including this cycle's grant.
      discard_d  = inflight_d;
      fetch_pc_d = word_align(flush_pc);
      resp_pc_d  = word_align(flush_pc);
      halted_d   = 1'b0;
      stale_d    = hold;
    end else begin
      if (grant && stale_q) begin
        discard_d = discard_d + CW'(1);
        stale_d   = 1'b0;
      end else if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (ibus_rvalid && discard_q != '0) discard_d = discard_d - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        if (ibus_err) halted_d = 1'b1;
      end
    end
    // Credit covers outstanding grants plus buffered entries, so every push has a slot.
    occ    = {1'b0, inflight_d} + {1'b0, count_d};
    req_d  = hold | (~halted_d & (occ < {1'b0, DEPTH_C}));
    addr_d = hold ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= BOOT_PC;
      fetch_pc_q <= BOOT_PC;
      resp_pc_q  <= BOOT_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      halted_q   <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
      stale_q    <= stale_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: resp_pc_q, instr: ibus_rdata, err: ibus_err}),
    .pop       (pop),
    .clear     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ibus_req    = req_q;
  assign ibus_addr   = addr_q;
  assign instr_valid = ~fifo_empty;
  assign instr_data  = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign instr_err   = fifo_head.err;

  a_counters: assert property (@(posedge clk) disable iff (rst)
    (inflight_q <= DEPTH_C) && (discard_q <= DEPTH_C));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench: ifetch_prefetch against a ROM slave with programmable grant delay and response latency.
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ibus_req, ibus_gnt = 1'b0, ibus_rvalid = 1'b0, ibus_err = 1'b0;
  logic [31:0] ibus_addr, ibus_rdata = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        instr_valid, instr_ready = 1'b0, instr_err;
  logic [31:0] instr_data, instr_pc;

  always #5 clk = ~clk;

  ifetch_prefetch #(.BOOT_ADDR(32'h0000_0100), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_err(instr_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        err;
    int          due;
  } rsp_t;

  int          nerr = 0, nchk = 0, cyc = 0;
  rsp_t        rq[$];
  logic [31:0] gaddr[$], pops[$];
  int          gcyc[$];
  bit          perr[$];
  int          dly_fixed = 0, dly_max = 0, lat_min = 0, lat_max = 0, rdy_mode = 0;
  int          cur_dly = 0, wctr = 0, last_due = 0;
  bit          flush_now = 0, fault_en = 0, prev_pend = 0;
  logic [31:0] flush_tgt = '0, fault_addr = '0, exp_pc = 32'h100, prev_addr = '0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int new_dly();
    return (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(dly_max, 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One bus cycle: slave, consumer and reference stream model, all driven at the falling edge.
  task automatic step();
    rsp_t r;
    @(negedge clk);
    cyc++;
    if (prev_pend) begin
      chk("req_held", ibus_req, 1);
      chk("addr_held", ibus_addr, prev_addr);
    end
    ibus_gnt = 1'b0;
    if (ibus_req) begin
      if (wctr >= cur_dly) begin
        ibus_gnt = 1'b1; wctr = 0; cur_dly = new_dly();
      end else wctr++;
    end
    ibus_rvalid = 1'b0; ibus_rdata = '0; ibus_err = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      ibus_rvalid = 1'b1; ibus_rdata = rom(r.addr); ibus_err = r.err;
    end
    if (ibus_gnt) begin
      int d;
      d = cyc + 1 + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      rq.push_back('{ibus_addr, fault_en && (ibus_addr == fault_addr), d});
      gaddr.push_back(ibus_addr);
      gcyc.push_back(cyc);
    end
    instr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
    flush = flush_now; flush_pc = flush_tgt; flush_now = 0;
    if (instr_valid && instr_ready && !flush) begin
      chk("pc", instr_pc, exp_pc);
      chk("data", instr_data, rom(exp_pc));
      chk("err", instr_err, fault_en && (exp_pc == fault_addr));
      pops.push_back(instr_pc);
      perr.push_back(instr_err);
      exp_pc += 32'd4;
    end
    if (flush) exp_pc = flush_pc & 32'hFFFF_FFFC;
    prev_pend = ibus_req && !ibus_gnt;
    prev_addr = ibus_addr;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_tgt = tgt; flush_now = 1; step();
    gaddr.delete(); gcyc.delete(); pops.delete(); perr.delete();
  endtask

  task automatic clear_slave();
    rq.delete(); last_due = 0; wctr = 0; cur_dly = new_dly(); prev_pend = 0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_err = 1'b0; flush = 1'b0;
    exp_pc = 32'h100;
    gaddr.delete(); gcyc.delete(); pops.delete(); perr.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1'b1; clear_slave();
    repeat (2) @(negedge clk);
    chk("rst_req", ibus_req, 0);
    chk("rst_addr", ibus_addr, 32'h100);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_err", instr_err, 0);
    rst = 1'b0;

    // Zero-wait streaming from boot
    repeat (20) step();
    chk("t1_a0", gaddr[0], 32'h100);
    chk("t1_a3", gaddr[3], 32'h10C);
    chk("t1_b2b", gcyc[3] - gcyc[0], 3);
    chk("t1_pop0", pops[0], 32'h100);
    chk("t1_npops", pops.size() >= 10, 1);

    // Decode stalled: credit limits to DEPTH fetches, one pop frees one
    rdy_mode = 1;
    do_flush(32'h400);
    repeat (20) step();
    chk("t2_ngnt", gaddr.size(), DEPTH);
    chk("t2_a0", gaddr[0], 32'h400);
    chk("t2_req0", ibus_req, 0);
    gaddr.delete();
    rdy_mode = 0; step(); rdy_mode = 1;
    repeat (10) step();
    chk("t2_one_more", gaddr.size(), 1);
    chk("t2_addr", gaddr[0], 32'h410);
    chk("t2_pop", pops[0], 32'h400);
    chk("t2_req1", ibus_req, 0);

    // Slave needing 3 wait cycles per grant
    rdy_mode = 0; dly_fixed = 3; cur_dly = 3; wctr = 0;
    do_flush(32'h500);
    repeat (40) step();
    chk("t3_a0", gaddr[0], 32'h500);
    chk("t3_a1", gaddr[1], 32'h504);
    chk("t3_gap1", gcyc[1] - gcyc[0], 4);
    chk("t3_gap2", gcyc[2] - gcyc[1], 4);
    chk("t3_npops", pops.size() >= 8, 1);

    // Flush with requests in flight and an entry buffered
    dly_fixed = 0; cur_dly = 0; lat_min = 3; lat_max = 3; rdy_mode = 1;
    do_flush(32'h600);
    begin
      int n = 0;
      while (!instr_valid && n < 20) begin step(); n++; end
    end
    chk("t4_buffered", instr_valid, 1);
    chk("t4_pending", rq.size() >= 2, 1);
    rdy_mode = 0;
    do_flush(32'h202);
    repeat (30) step();
    chk("t4_pop0", pops[0], 32'h200);
    chk("t4_pop1", pops[1], 32'h204);

    // Bus error halts fetching until a redirect
    lat_min = 0; lat_max = 0; fault_en = 1; fault_addr = 32'h10C;
    do_flush(32'h100);
    repeat (30) step();
    chk("t5_errpc", pops[3], 32'h10C);
    chk("t5_errflag", perr[3], 1);
    gaddr.delete();
    repeat (10) step();
    chk("t5_nogrant", gaddr.size(), 0);
    chk("t5_req0", ibus_req, 0);
    fault_en = 0;
    do_flush(32'h0);
    repeat (20) step();
    chk("t5_resume0", pops[0], 32'h0);
    chk("t5_resume1", pops[1], 32'h4);

    // Address wrap, then asynchronous reset mid-burst
    do_flush(32'hFFFF_FFF8);
    repeat (12) step();
    chk("t6_a1", gaddr[1], 32'hFFFF_FFFC);
    chk("t6_wrap", gaddr[2], 32'h0);
    chk("t6_popwrap", pops[2], 32'h0);
    @(negedge clk); #2;
    chk("t6_busy", ibus_req, 1);
    rst = 1'b1; #1;
    chk("t6_rst_req", ibus_req, 0);
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_addr", ibus_addr, 32'h100);
    clear_slave();
    @(negedge clk); rst = 1'b0;
    repeat (10) step();
    chk("t6_boot_a0", gaddr[0], 32'h100);
    chk("t6_boot_pop", pops[0], 32'h100);

    // Randomized traffic with random redirects, back-to-back flushes and faults
    dly_fixed = -1; dly_max = 3; lat_min = 0; lat_max = 3; rdy_mode = 2;
    pops.delete();
    begin
      bit dbl = 0;
      int total = 0;
      repeat (3000) begin
        if (dbl || $urandom_range(49, 0) == 0) begin
          flush_tgt  = $urandom;
          fault_en   = ($urandom_range(2, 0) == 0);
          fault_addr = (flush_tgt & 32'hFFFF_FFFC) + 32'(4 * $urandom_range(12, 0));
          flush_now  = 1;
          dbl = !dbl && ($urandom_range(3, 0) == 0);
        end
        step();
      end
      total = pops.size();
      chk("t7_progress", total > 200, 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
